// File: rtl/sensor_poll_scheduler.sv
// Millisecond time base and fixed-priority sensor bus scheduler.
// Four periodic poll slots share one bus via a START/DONE handshake.
module sensor_poll_scheduler #(
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned PERIOD0  = 1,
   parameter int unsigned PERIOD1  = 10,
   parameter int unsigned PERIOD2  = 100,
   parameter int unsigned PERIOD3  = 1000,
   parameter int unsigned TIMEOUT  = 800
) (
   input  logic       CLK_1MHZ_IN,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic [3:0] DONE,
   input  logic       ERR_CLR,
   output logic [3:0] START,
   output logic       BUSY,
   output logic [1:0] ACTIVE_ID,
   output logic       MS_TICK,
   output logic [3:0] TIMEOUT_ERR,
   output logic [3:0] OVERRUN
);

   localparam int unsigned MSW = $clog2(TICK_DIV);
   localparam int unsigned TOW = $clog2(TIMEOUT);
   localparam logic [MSW-1:0] MS_LAST = MSW'(TICK_DIV - 1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
   localparam logic [3:0][15:0] PC_LAST = {
      16'(PERIOD3 - 1), 16'(PERIOD2 - 1),
      16'(PERIOD1 - 1), 16'(PERIOD0 - 1)
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [MSW-1:0]   ms_cnt_q, ms_cnt_d;
   logic             ms_tick_q, ms_tick_d;
   logic [3:0][15:0] pc_q, pc_d;
   logic [3:0]       pend_q, pend_d;
   logic [TOW-1:0]   to_cnt_q, to_cnt_d;
   logic [1:0]       act_q, act_d;
   logic [3:0]       start_q, start_d;
   logic             busy_q, busy_d;
   logic [3:0]       terr_q, terr_d;
   logic [3:0]       ovr_q, ovr_d;
   logic [1:0]       sel;
   logic [3:0]       grant_clr;
   logic [3:0]       ovr_set;
   logic [3:0]       terr_set;

   always_comb begin
      ms_tick_d = (ms_cnt_q == MS_LAST);
      ms_cnt_d  = ms_tick_d ? '0 : ms_cnt_q + MSW'(1);
   end

   // Lowest index wins: scan downwards so slot 0 is assigned last.
   always_comb begin
      sel = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pend_q[i]) sel = 2'(i);
      end
   end

   always_comb begin
      pc_d      = pc_q;
      pend_d    = pend_q;
      ovr_set   = '0;
      grant_clr = '0;
      if (state_q == S_GRANT) grant_clr = 4'b0001 << act_q;
      for (int i = 0; i < 4; i++) begin
         pend_d[i] = pend_q[i] & ~grant_clr[i];
         if (!ENABLE) begin
            pc_d[i]   = '0;
            pend_d[i] = 1'b0;
         end else if (ms_tick_q) begin
            if (pc_q[i] == PC_LAST[i]) begin
               pc_d[i]    = '0;
               pend_d[i]  = 1'b1;
               ovr_set[i] = pend_q[i] & ~grant_clr[i];
            end else begin
               pc_d[i] = pc_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      act_d    = act_q;
      start_d  = '0;
      to_cnt_d = to_cnt_q;
      terr_set = '0;
      unique case (state_q)
         S_IDLE: begin
            if (ENABLE && (pend_q != 4'b0000)) begin
               state_d = S_GRANT;
               act_d   = sel;
               start_d = 4'b0001 << sel;
            end
         end
         S_GRANT: begin
            state_d  = S_WAIT;
            to_cnt_d = '0;
         end
         S_WAIT: begin
            to_cnt_d = to_cnt_q + TOW'(1);
            if (DONE[act_q]) begin
               state_d = S_IDLE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d  = S_IDLE;
               terr_set = 4'b0001 << act_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      // Clear first, then OR in sets so a same-cycle set survives.
      terr_d = (ERR_CLR ? 4'b0000 : terr_q) | terr_set;
      ovr_d  = (ERR_CLR ? 4'b0000 : ovr_q) | ovr_set;
   end

   always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         ms_cnt_q  <= '0;
         ms_tick_q <= 1'b0;
         pc_q      <= '0;
         pend_q    <= '0;
         to_cnt_q  <= '0;
         act_q     <= '0;
         start_q   <= '0;
         busy_q    <= 1'b0;
         terr_q    <= '0;
         ovr_q     <= '0;
      end else begin
         state_q   <= state_d;
         ms_cnt_q  <= ms_cnt_d;
         ms_tick_q <= ms_tick_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         to_cnt_q  <= to_cnt_d;
         act_q     <= act_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         terr_q    <= terr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign START       = start_q;
   assign BUSY        = busy_q;
   assign ACTIVE_ID   = act_q;
   assign MS_TICK     = ms_tick_q;
   assign TIMEOUT_ERR = terr_q;
   assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler: two instances cover
// tick/priority/timeout timing and overrun behaviour.
module tb_sensor_poll_scheduler;

   logic       clk;
   logic       rst_a, en_a, clr_a;
   logic [3:0] done_a;
   logic [3:0] start_a, terr_a, ovr_a;
   logic       busy_a, tick_a;
   logic [1:0] act_a;
   logic       rst_b, en_b, clr_b;
   logic [3:0] done_b;
   logic [3:0] start_b, terr_b, ovr_b;
   logic       busy_b, tick_b;
   logic [1:0] act_b;

   int         checks;
   int         errors;
   int         cyc;
   int         busy_len;
   logic [3:0] ack_a;
   logic [3:0] extra_a;
   logic [3:0] seen_a;
   logic       mon;

   sensor_poll_scheduler #(
      .TICK_DIV(10), .PERIOD0(1), .PERIOD1(2),
      .PERIOD2(4), .PERIOD3(8), .TIMEOUT(5)
   ) u_a (
      .CLK_1MHZ_IN(clk),
      .RESET(rst_a),
      .ENABLE(en_a),
      .DONE(done_a),
      .ERR_CLR(clr_a),
      .START(start_a),
      .BUSY(busy_a),
      .ACTIVE_ID(act_a),
      .MS_TICK(tick_a),
      .TIMEOUT_ERR(terr_a),
      .OVERRUN(ovr_a)
   );

   sensor_poll_scheduler #(
      .TICK_DIV(4), .PERIOD0(1), .PERIOD1(1000),
      .PERIOD2(1000), .PERIOD3(1000), .TIMEOUT(20)
   ) u_b (
      .CLK_1MHZ_IN(clk),
      .RESET(rst_b),
      .ENABLE(en_b),
      .DONE(done_b),
      .ERR_CLR(clr_b),
      .START(start_b),
      .BUSY(busy_b),
      .ACTIVE_ID(act_b),
      .MS_TICK(tick_b),
      .TIMEOUT_ERR(terr_b),
      .OVERRUN(ovr_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   // Driver model for instance A: acks in the first WAIT cycle
   // for slots enabled in ack_a, plus any forced extra_a bits.
   task automatic step();
      @(negedge clk);
      cyc++;
      done_a = extra_a;
      if (busy_a && start_a == 4'd0 && ack_a[act_a])
         done_a[act_a] = 1'b1;
      if (mon) seen_a = seen_a | start_a;
   endtask

   task automatic go(input int c);
      while (cyc < c) step();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      rst_a   = 1'b1;
      rst_b   = 1'b1;
      en_a    = 1'b0;
      en_b    = 1'b1;
      clr_a   = 1'b0;
      clr_b   = 1'b0;
      done_a  = '0;
      done_b  = '0;
      ack_a   = 4'hF;
      extra_a = '0;
      seen_a  = '0;
      mon     = 1'b0;
      step();
      step();
      chk("rst_a", {start_a, busy_a, act_a, tick_a, terr_a, ovr_a}, 0);
      chk("rst_b", {start_b, busy_b, act_b, tick_b, terr_b, ovr_b}, 0);

      rst_a = 1'b0;
      cyc   = 0;
      mon   = 1'b1;
      go(9);  chk("tick_c9", tick_a, 0);
      go(10); chk("tick_c10", tick_a, 1);
      go(11); chk("tick_c11", tick_a, 0);
      go(20); chk("tick_c20", tick_a, 1);
      go(30); chk("tick_c30", tick_a, 1);
      chk("no_start_dis", {seen_a, busy_a}, 0);
      mon = 1'b0;
      go(31);
      en_a = 1'b1;

      go(42); chk("t1_s0", start_a, 4'b0001);
      go(43); chk("t1_wait", {start_a, busy_a}, 5'b00001);
      go(44); chk("t1_idle", busy_a, 0);
      go(45); chk("t1_only", start_a, 0);
      go(52); chk("t2_s0", start_a, 4'b0001);
      go(55); chk("t2_s1", {start_a, act_a}, 6'b0010_01);
      go(58); chk("t2_done", busy_a, 0);
      go(72); chk("t4_s0", start_a, 4'b0001);
      go(75); chk("t4_s1", start_a, 4'b0010);
      go(78); chk("t4_s2", start_a, 4'b0100);
      go(112); chk("t8_s0", start_a, 4'b0001);
      go(115); chk("t8_s1", start_a, 4'b0010);
      go(118); chk("t8_s2", start_a, 4'b0100);
      go(121); chk("t8_s3", start_a, 4'b1000);

      go(140);
      ack_a = 4'b1011;
      go(157); chk("to_pre", busy_a, 0);
      busy_len = 0;
      repeat (7) begin
         step();
         busy_len += int'(busy_a);
      end
      chk("to_busy_len", busy_len, 6);
      chk("to_err", {busy_a, terr_a}, 5'b0_0100);
      go(165); chk("to_next", start_a, 4'b0001);
      clr_a = 1'b1;
      go(166);
      clr_a = 1'b0;
      chk("to_clr", terr_a, 0);
      ack_a = 4'b1101;

      go(174);
      extra_a = 4'b0010;
      go(175); chk("dg_start", start_a, 4'b0010);
      extra_a = 4'b0000;
      go(180); chk("dg_wait", busy_a, 1);
      go(181); chk("dg_err", {busy_a, terr_a}, 5'b0_0010);
      clr_a = 1'b1;
      go(182);
      clr_a = 1'b0;
      chk("dg_clr", terr_a, 0);

      go(195); chk("dt_s1", start_a, 4'b0010);
      go(199);
      extra_a = 4'b0010;
      go(200); chk("dt_last", busy_a, 1);
      extra_a = 4'b0000;
      go(201); chk("dt_noerr", {busy_a, terr_a}, 0);
      go(202); chk("dt_s0", start_a, 4'b0001);
      go(205); chk("dt_s2", start_a, 4'b0100);
      go(208); chk("dt_s3", start_a, 4'b1000);

      go(215); chk("fd_s1", {start_a, act_a}, 6'b0010_01);
      extra_a = 4'b1000;
      go(217); chk("fd_ign", busy_a, 1);
      extra_a = 4'b0010;
      go(218); chk("fd_hold", {busy_a, act_a}, 3'b1_01);
      extra_a = 4'b0000;
      go(219); chk("fd_done", {busy_a, terr_a}, 0);
      ack_a = 4'hF;

      go(236); chk("rw_pre", {busy_a, act_a}, 3'b1_01);
      rst_a = 1'b1;
      #1;
      chk("rw_async",
          {start_a, busy_a, act_a, tick_a, terr_a, ovr_a}, 0);
      step();
      rst_a = 1'b0;
      cyc   = 0;
      go(11); chk("rw_c11", {start_a, busy_a}, 0);
      go(12); chk("rw_c12", start_a, 4'b0001);

      rst_b = 1'b0;
      cyc   = 0;
      go(6);  chk("ov_grant", start_b, 4'b0001);
      go(12); chk("ov_c12", ovr_b, 0);
      go(13); chk("ov_set", ovr_b, 4'b0001);
      go(14);
      clr_b = 1'b1;
      go(15);
      clr_b = 1'b0;
      chk("ov_clr", ovr_b, 0);
      go(16);
      clr_b = 1'b1;
      go(17);
      clr_b = 1'b0;
      chk("ov_clr_race", ovr_b, 4'b0001);
      go(26); chk("ov_wait", {busy_b, terr_b}, 5'b1_0000);
      go(27); chk("ov_to", {busy_b, terr_b}, 5'b0_0001);
      clr_b = 1'b1;
      go(28);
      clr_b = 1'b0;
      chk("ov_regrant", {start_b, ovr_b, terr_b}, 12'h100);
      go(29); chk("ov_set_wins", ovr_b, 0);
      go(33); chk("ov_pend_kept", ovr_b, 4'b0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
